arbiter_rr_4x8: RTL and testbench
=================================

// Module: arbiter_rr_4x8
// PURPOSE
//  Round-robin arbiter/router that drains four upstream fifo_6x8 virtual-channel FIFOs.
//  Each cycle it selects at most one non-empty source and pops one word from it.
//  The word's 2-bit destination field selects which of four downstream fifo_6x8 instances receives the push.
//  Downstream pause (almost_full) backpressures all popping; words already in flight are always delivered.
// PARAMETERS
//  DATA_SIZE  8  word width (matches fifo_6x8 DATA_SIZE)
//  DEST_MSB   5  MSB of 2-bit destination field data[DEST_MSB:DEST_MSB-1]; 1 <= DEST_MSB <= DATA_SIZE-1
// PORTS
//  clk          in   1            single clock; all state updates on posedge
//  reset        in   1            synchronous, active-low reset
//  src_empty    in   4            fifo_empty of upstream FIFO i (bit i)
//  src_data0..3 in   DATA_SIZE    data_out_pop of upstream FIFO 0..3
//  dst_pause    in   4            fifo_pause of downstream FIFO j
//  dst_full     in   4            Fifo_full of downstream FIFO j
//  src_pop      out  4            read strobe to upstream FIFO i; one-hot or zero
//  dst_push     out  4            write strobe to downstream FIFO j; one-hot or zero
//  data_out     out  DATA_SIZE    word driven to every downstream FIFO's data_in_push
//  arb_state    out  2            0 IDLE, 1 ACTIVE, 2 PAUSED
//  route_error  out  1            sticky; set when a push targets a full destination
// BEHAVIOUR
//  Reset (reset==0 at posedge): all outputs 0, state IDLE, rr_ptr=0, pipeline valids cleared.
//   In-flight words are discarded.
//  Registered outputs: src_pop, dst_push, data_out, arb_state, and route_error are all flops.
//  Eligibility for source i: src_empty[i]==0, i not granted in the previous cycle, and dst_pause==4'b0.
//   The previous-cycle mask is required because the upstream empty flag lags a pop by one cycle.
//  Grant: the first eligible i scanning rr_ptr, rr_ptr+1, ... mod 4.
//   On a grant, src_pop[i]=1 for one cycle and rr_ptr <= i+1 (mod 4).
//  Pipeline: src_pop[i] is high in cycle c.
//   The arbiter samples src_data_i at the end of cycle c+1, since the upstream word is registered at that edge.
//   In cycle c+2: data_out holds the sampled word and dst_push[d]=1, with d = word[DEST_MSB:DEST_MSB-1].
//   Pop-to-push latency is 2 cycles. Throughput is 1 word/cycle when at least 2 sources are non-empty.
//   A single active source yields 1 word per 2 cycles.
//  Stage 1 holds {valid, src index}; stage 2 holds {valid, word}. Both stages always advance; there is no stall inside the pipe.
//  dst_pause!=0 blocks new grants only. At most 2 in-flight words still push.
//   Downstream almost_full margin (>=2 free entries) absorbs them.
//  If dst_full[d]==1 in the push cycle: the push is still issued and route_error <= 1 (sticky until reset).
//  dst_push stays 0 whenever stage 2 is invalid. data_out holds its last value when no push occurs.
//  FSM, evaluated each cycle, in priority order:
//   PAUSED if dst_pause!=0.
//   ACTIVE if any src_empty==0 or a pipe stage is valid.
//   IDLE otherwise.
//  Recorded transitions:
//   IDLE->ACTIVE when a source becomes non-empty.
//   ACTIVE->PAUSED when dst_pause rises.
//   PAUSED->ACTIVE/IDLE when dst_pause clears.
//   ACTIVE->IDLE when all sources are empty and the pipe is drained.
//  Simultaneous pause rise and eligible source: pause wins; no pop is issued.
//  rr_ptr wraps 3->0. Source order is fair: no source waits more than 3 grants.
// TESTING
//  1. Reset: hold reset=0 for 2 clk with sources non-empty -> src_pop=0, dst_push=0, data_out=0, arb_state=0, route_error=0.
//  2. Round-robin: all src non-empty, src_dataN=8'h0N|(N<<4) -> pops 1,2,4,8,1... cycle by cycle.
//     dst_push 2 cycles after each pop, one-hot at index N, data_out matches the source word.
//  3. Single source: only src 2 non-empty holding 3 words -> src_pop=4'b0100 on alternating cycles.
//     Never two consecutive pops; 3 pushes total.
//  4. Backpressure: dst_pause[1]=1 mid-stream -> src_pop=0 from that cycle.
//     The <=2 in-flight pushes complete, arb_state=2. Clearing pause resumes from rr_ptr with no skipped source.
//  5. Error: dst_full[3]=1 and a word with dest=3 arrives -> dst_push=4'b1000.
//     route_error=1 the following cycle and it stays 1 until reset.
//  6. Reset mid-stream with 2 words in flight -> no push after the reset edge; rr_ptr back to 0 (source 0 granted first).

Source files
------------

// File: rtl/arbiter_rr_4x8.sv
// Round-robin arbiter/router that drains four upstream FIFOs and pushes each word
// into one of four downstream FIFOs chosen by the word's 2-bit destination field.
module arbiter_rr_4x8 #(
    parameter int DATA_SIZE = 8,
    parameter int DEST_MSB  = 5
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [3:0]           src_empty_i,
    input  logic [DATA_SIZE-1:0] src_data0_i,
    input  logic [DATA_SIZE-1:0] src_data1_i,
    input  logic [DATA_SIZE-1:0] src_data2_i,
    input  logic [DATA_SIZE-1:0] src_data3_i,
    input  logic [3:0]           dst_pause_i,
    input  logic [3:0]           dst_full_i,
    output logic [3:0]           src_pop_o,
    output logic [3:0]           dst_push_o,
    output logic [DATA_SIZE-1:0] data_out_o,
    output logic [1:0]           arb_state_o,
    output logic                 route_error_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSED = 2'd2
    } arbStateE;

    arbStateE             state_q, state_d;
    logic [1:0]           rrPtr_q, rrPtr_d;
    logic [3:0]           srcPop_q, srcPop_d;
    logic                 stage1Valid_q, stage1Valid_d;
    logic [1:0]           stage1Idx_q, stage1Idx_d;
    logic [3:0]           dstPush_q, dstPush_d;
    logic [DATA_SIZE-1:0] dataOut_q, dataOut_d;
    logic                 routeError_q, routeError_d;

    logic [3:0]           eligible;
    logic [1:0]           scanIdx;
    logic                 found;
    logic [DATA_SIZE-1:0] stage1Word;
    logic                 pipeBusy;

    // A source popped last cycle still shows non-empty, so it is masked for one cycle.
    always_comb begin
        eligible = ~src_empty_i & ~srcPop_q & {4{dst_pause_i == 4'b0000}};
        srcPop_d = 4'b0000;
        rrPtr_d  = rrPtr_q;
        scanIdx  = rrPtr_q;
        found    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            scanIdx = rrPtr_q + 2'(k);
            if (!found && eligible[scanIdx]) begin
                found             = 1'b1;
                srcPop_d[scanIdx] = 1'b1;
                rrPtr_d           = scanIdx + 2'd1;
            end
        end
    end

    always_comb begin
        stage1Valid_d = |srcPop_q;
        stage1Idx_d   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (srcPop_q[i]) begin
                stage1Idx_d = 2'(i);
            end
        end
    end

    // The upstream word becomes valid the cycle after its pop, so stage 1 selects it then.
    always_comb begin
        case (stage1Idx_q)
            2'd0:    stage1Word = src_data0_i;
            2'd1:    stage1Word = src_data1_i;
            2'd2:    stage1Word = src_data2_i;
            default: stage1Word = src_data3_i;
        endcase
        dstPush_d = 4'b0000;
        dataOut_d = dataOut_q;
        if (stage1Valid_q) begin
            dstPush_d = 4'b0001 << stage1Word[DEST_MSB -: 2];
            dataOut_d = stage1Word;
        end
        routeError_d = routeError_q | (|(dstPush_q & dst_full_i));
    end

    always_comb begin
        pipeBusy = stage1Valid_q | (|dstPush_q);
        state_d  = IDLE;
        if (dst_pause_i != 4'b0000) begin
            state_d = PAUSED;
        end else if ((src_empty_i != 4'b1111) || pipeBusy) begin
            state_d = ACTIVE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q       <= IDLE;
            rrPtr_q       <= 2'd0;
            srcPop_q      <= 4'b0000;
            stage1Valid_q <= 1'b0;
            stage1Idx_q   <= 2'd0;
            dstPush_q     <= 4'b0000;
            dataOut_q     <= '0;
            routeError_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rrPtr_q       <= rrPtr_d;
            srcPop_q      <= srcPop_d;
            stage1Valid_q <= stage1Valid_d;
            stage1Idx_q   <= stage1Idx_d;
            dstPush_q     <= dstPush_d;
            dataOut_q     <= dataOut_d;
            routeError_q  <= routeError_d;
        end
    end

    assign src_pop_o     = srcPop_q;
    assign dst_push_o    = dstPush_q;
    assign data_out_o    = dataOut_q;
    assign arb_state_o   = state_q;
    assign route_error_o = routeError_q;

endmodule

// File: tb/tb_arbiter_rr_4x8.sv
// Bench for arbiter_rr_4x8: behavioural upstream FIFOs plus a transaction-level
// reference model of grants, scheduled pushes, state and the sticky error flag.
module tb_arbiter_rr_4x8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] srcEmpty, dstPause, dstFull;
    logic [7:0] srcData [4];
    logic [3:0] srcPop, dstPush;
    logic [7:0] dataOut;
    logic [1:0] arbState;
    logic       routeError;

    always #5 clk = ~clk;

    arbiter_rr_4x8 #(.DATA_SIZE(8), .DEST_MSB(5)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .src_empty_i  (srcEmpty),
        .src_data0_i  (srcData[0]),
        .src_data1_i  (srcData[1]),
        .src_data2_i  (srcData[2]),
        .src_data3_i  (srcData[3]),
        .dst_pause_i  (dstPause),
        .dst_full_i   (dstFull),
        .src_pop_o    (srcPop),
        .dst_push_o   (dstPush),
        .data_out_o   (dataOut),
        .arb_state_o  (arbState),
        .route_error_o(routeError)
    );

    typedef struct {
        int         due;
        logic [7:0] word;
    } pendT;

    int         errorCount = 0;
    int         checkCount = 0;
    logic [7:0] fifoQ [4][$];
    pendT       pend [$];
    int         cyc = 0;
    int         mPtr = 0;
    logic [3:0] mPop = 4'b0000;
    logic [7:0] mData = 8'h00;
    logic [1:0] mState = 2'd0;
    logic       mErr = 1'b0;
    logic [3:0] lastPush = 4'b0000;
    int         pushSeen = 0;
    int         popSeen = 0;
    int         backToBack = 0;
    logic [3:0] prevPopSeen = 4'b0000;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, actual, expected);
        end
    endtask

    // One clock: drive inputs, advance the model, update the upstream FIFOs, compare.
    task automatic applyStimulus(input logic rstn, input logic [3:0] pause, input logic [3:0] full);
        logic [3:0] empty, nPop, expPush, popNow;
        bit         pipeBusy, found;
        int         j;
        for (int i = 0; i < 4; i++) empty[i] = (fifoQ[i].size() == 0);
        reset    = rstn;
        srcEmpty = empty;
        dstPause = pause;
        dstFull  = full;
        popNow   = srcPop;
        @(posedge clk);
        #1;
        cyc++;
        if (!rstn) begin
            mPop = 4'b0000; mPtr = 0; pend.delete();
            mData = 8'h00; mState = 2'd0; mErr = 1'b0;
        end else begin
            mErr = mErr | (|(lastPush & full));
            while (pend.size() > 0 && pend[0].due < cyc - 1) void'(pend.pop_front());
            pipeBusy = 0;
            foreach (pend[k]) if (pend[k].due == cyc || pend[k].due == cyc - 1) pipeBusy = 1;
            mState = (pause != 0) ? 2'd2 : ((empty != 4'hF || pipeBusy) ? 2'd1 : 2'd0);
            nPop = 4'b0000;
            found = 0;
            if (pause == 0) begin
                for (int k = 0; k < 4; k++) begin
                    j = (mPtr + k) % 4;
                    if (!found && !empty[j] && !mPop[j] && fifoQ[j].size() > 0) begin
                        found = 1;
                        nPop[j] = 1'b1;
                        mPtr = (j + 1) % 4;
                        pend.push_back('{cyc + 2, fifoQ[j][0]});
                    end
                end
            end
            mPop = nPop;
        end
        expPush = 4'b0000;
        foreach (pend[k]) begin
            if (pend[k].due == cyc) begin
                expPush = 4'b0001 << pend[k].word[5:4];
                mData   = pend[k].word;
            end
        end
        lastPush = expPush;
        for (int i = 0; i < 4; i++) begin
            if (popNow[i] === 1'b1 && fifoQ[i].size() > 0) srcData[i] = fifoQ[i].pop_front();
        end
        if (dstPush != 0) pushSeen++;
        if (srcPop != 0) popSeen++;
        if ((prevPopSeen & srcPop) != 0) backToBack++;
        prevPopSeen = srcPop;
        checkOutput("src_pop", 32'(srcPop), 32'(mPop));
        checkOutput("dst_push", 32'(dstPush), 32'(expPush));
        checkOutput("data_out", 32'(dataOut), 32'(mData));
        checkOutput("arb_state", 32'(arbState), 32'(mState));
        checkOutput("route_error", 32'(routeError), 32'(mErr));
    endtask

    task automatic clearFifos();
        for (int i = 0; i < 4; i++) fifoQ[i].delete();
    endtask

    task automatic fillPattern(input int depth);
        for (int i = 0; i < 4; i++)
            for (int n = 0; n < depth; n++) fifoQ[i].push_back(8'((i << 4) | i));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) srcData[i] = 8'h00;
        reset = 1'b0; srcEmpty = 4'hF; dstPause = 4'h0; dstFull = 4'h0;

        // Reset held with all sources non-empty
        fillPattern(4);
        applyStimulus(1'b0, 4'h0, 4'h0);
        applyStimulus(1'b0, 4'h0, 4'h0);

        // Round-robin with every source busy
        clearFifos();
        fillPattern(6);
        for (int n = 0; n < 14; n++) applyStimulus(1'b1, 4'h0, 4'h0);

        // Single source with three words
        applyStimulus(1'b0, 4'h0, 4'h0);
        clearFifos();
        fifoQ[2].push_back(8'h21); fifoQ[2].push_back(8'h05); fifoQ[2].push_back(8'h3C);
        pushSeen = 0; popSeen = 0; backToBack = 0; prevPopSeen = 4'b0000;
        for (int n = 0; n < 10; n++) applyStimulus(1'b1, 4'h0, 4'h0);
        checkOutput("single_pops", 32'(popSeen), 32'd3);
        checkOutput("single_pushes", 32'(pushSeen), 32'd3);
        checkOutput("single_b2b", 32'(backToBack), 32'd0);

        // Backpressure mid-stream
        clearFifos();
        fillPattern(5);
        for (int n = 0; n < 5; n++) applyStimulus(1'b1, 4'h0, 4'h0);
        for (int n = 0; n < 5; n++) applyStimulus(1'b1, 4'b0010, 4'h0);
        for (int n = 0; n < 8; n++) applyStimulus(1'b1, 4'h0, 4'h0);

        // Push into a full destination sets the sticky error
        applyStimulus(1'b0, 4'h0, 4'h0);
        clearFifos();
        fifoQ[3].push_back(8'h3A);
        for (int n = 0; n < 5; n++) applyStimulus(1'b1, 4'h0, 4'b1000);
        for (int n = 0; n < 4; n++) applyStimulus(1'b1, 4'h0, 4'h0);
        checkOutput("error_sticky", 32'(routeError), 32'd1);
        applyStimulus(1'b0, 4'h0, 4'h0);

        // Reset with words in flight, then source 0 first
        clearFifos();
        fillPattern(4);
        for (int n = 0; n < 4; n++) applyStimulus(1'b1, 4'h0, 4'h0);
        applyStimulus(1'b0, 4'h0, 4'h0);
        for (int n = 0; n < 3; n++) applyStimulus(1'b1, 4'h0, 4'h0);

        // Randomized traffic with occasional pause and full
        begin
            logic [3:0] pause, full;
            int         pauseLeft = 0;
            for (int n = 0; n < 400; n++) begin
                for (int i = 0; i < 4; i++)
                    if (fifoQ[i].size() < 6 && $urandom_range(0, 3) == 0)
                        fifoQ[i].push_back(8'($urandom));
                if (pauseLeft > 0) pauseLeft--;
                else if ($urandom_range(0, 15) == 0) pauseLeft = $urandom_range(1, 4);
                pause = (pauseLeft > 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'h0;
                full  = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'h0;
                applyStimulus((n == 200) ? 1'b0 : 1'b1, pause, full);
            end
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
